// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR core with one signed multiply-accumulator.
// Each accepted sample costs TAPS MAC cycles plus one output cycle.
// Coefficients shift in serially while idle, and the delay line persists across samples.
// Build option FIR_SAT_EN: when defined, the output saturates to OUT_W bits.
// When it is undefined, the output keeps the low OUT_W bits (two's-complement wrap).
module fir_mac_seq #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 10,
  parameter int SHIFT  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     coef_load,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     busy
);
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int IDX_W  = $clog2(TAPS);
  localparam int WIDE_W = ACC_W + OUT_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state, state_nx;

  logic signed [DATA_W-1:0] x    [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [IDX_W-1:0]         idx;
  logic                     accept, load;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [WIDE_W-1:0] acc_sh;
  logic signed [OUT_W-1:0]  scaled;

  // A coefficient load takes priority, so it masks the sample handshake.
  assign in_ready = (state == IDLE) && !coef_load;
  assign accept   = in_valid && in_ready;
  assign load     = (state == IDLE) && coef_load;
  assign busy     = (state != IDLE);

  // The operands are sign-extended before multiplying, so the product stays full precision.
  assign prod     = PROD_W'(x[idx]) * PROD_W'(coef[idx]);
  assign prod_ext = ACC_W'(prod);
  // The accumulator is widened before the shift, so saturation can compare the full value.
  assign acc_sh   = WIDE_W'(acc) >>> SHIFT;

`ifdef FIR_SAT_EN
  localparam logic signed [WIDE_W-1:0] MAX_V = (WIDE_W'(1) <<< (OUT_W - 1)) - WIDE_W'(1);
  localparam logic signed [WIDE_W-1:0] MIN_V = ~MAX_V;
  // Clamp the scaled accumulator into the signed OUT_W range.
  always_comb begin
    scaled = OUT_W'(acc_sh);
    if (acc_sh > MAX_V)      scaled = OUT_W'(MAX_V);
    else if (acc_sh < MIN_V) scaled = OUT_W'(MIN_V);
  end
`else
  assign scaled = OUT_W'(acc_sh);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Sequencing: IDLE -> MAC for TAPS cycles -> DONE for one cycle -> IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = MAC;
      MAC:     if (idx == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Delay line shifts on each accept; the coefficient chain shifts on each idle load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        x[k]    <= '0;
        coef[k] <= '0;
      end
    end else begin
      if (load) begin
        for (int k = 0; k < TAPS - 1; k++) coef[k] <= coef[k+1];
        coef[TAPS-1] <= coef_data;
      end
      if (accept) begin
        x[0] <= in_data;
        for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
      end
    end
  end

  // Accumulator and tap index: cleared on accept, stepped once per MAC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      idx <= '0;
    end else if (accept) begin
      acc <= '0;
      idx <= '0;
    end else if (state == MAC) begin
      acc <= acc + prod_ext;
      idx <= idx + IDX_W'(1);
    end
  end

  // Result register: the DONE cycle drives a one-cycle valid pulse, and the data holds until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= (state == DONE);
      if (state == DONE) out_data <= scaled;
    end
  end
endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq at default parameters.
// It uses fixed vector tables, hand-written corner sequences and random samples.
// A reference model computes y = sum(c_k * x[n-k]) >>> 6 directly.
module tb_fir_mac_seq;
  localparam int TAPS = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, coef_load, out_valid, busy;
  logic signed [7:0] in_data, coef_data;
  logic signed [9:0] out_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mc   [TAPS];
  int hist [TAPS];

  typedef struct {int sample; int exp;} vec_t;
  typedef struct {int c; int s; int exp;} ovf_t;
  vec_t imp [TAPS];
  ovf_t ovf [2];

  fir_mac_seq #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(10), .SHIFT(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_load(coef_load), .coef_data(coef_data), .out_valid(out_valid), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int scale(longint s);
`ifdef FIR_SAT_EN
    if (s > 511)  return 511;
    if (s < -512) return -512;
    return int'(s);
`else
    longint v = s & 1023;
    if (v >= 512) v = v - 1024;
    return int'(v);
`endif
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) begin
      mc[k]   = 0;
      hist[k] = 0;
    end
  endfunction

  // Push the newest sample into the history, then compute the filter output.
  function automatic int model_accept(int s);
    longint a = 0;
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    for (int k = 0; k < TAPS; k++) a += longint'(mc[k]) * longint'(hist[k]);
    return scale(a >>> 6);
  endfunction

  task automatic load_coef(input int w);
    @(negedge clk);
    coef_load = 1'b1;
    coef_data = 8'(w);
    @(posedge clk); #1;
    coef_load = 1'b0;
    for (int k = 0; k < TAPS - 1; k++) mc[k] = mc[k+1];
    mc[TAPS-1] = w;
  endtask

  // Offer one sample, then wait a bounded time for its result.
  // When poke is set, coef_load is pulsed with -1 during the MAC cycles.
  task automatic run_sample(input int s, input bit poke, output int y, output int lat);
    int w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'(s);
    while (!in_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (poke) begin
        coef_load = (lat <= 3);
        coef_data = 8'hFF;
      end
    end while (!out_valid && lat < 30);
    coef_load = 1'b0;
    y = int'(out_data);
  endtask

  initial begin
    int y, lat, e, last, nacc, r;
    bit hs_done;

    for (int i = 0; i < TAPS; i++) begin
      imp[i].sample = (i == 0) ? 64 : 0;
      imp[i].exp    = (i < 7) ? (64 >> i) : 0;
    end
`ifdef FIR_SAT_EN
    ovf[0] = '{c: 127, s: 127,  exp: 511};
    ovf[1] = '{c: 127, s: -128, exp: -512};
`else
    ovf[0] = '{c: 127, s: 127,  exp: -32};
    ovf[1] = '{c: 127, s: -128, exp: 16};
`endif

    // Reset state.
    rst_n = 1'b0; in_valid = 1'b0; coef_load = 1'b0; in_data = '0; coef_data = '0;
    model_reset();
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Impulse response, driven from the vector table.
    for (int i = 0; i < TAPS; i++) load_coef((i < 7) ? (64 >> i) : 0);
    for (int i = 0; i < TAPS; i++) begin
      run_sample(imp[i].sample, 1'b0, y, lat);
      void'(model_accept(imp[i].sample));
      check("impulse_y", y, imp[i].exp);
      check("impulse_lat", lat, 9);
    end

    // Overflow handling: saturate or wrap, depending on the build.
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < TAPS; i++) load_coef(ovf[t].c);
      for (int j = 0; j < TAPS; j++) begin
        run_sample(ovf[t].s, 1'b0, y, lat);
        e = model_accept(ovf[t].s);
        check("ovf_model", y, e);
      end
      check("ovf_last", y, ovf[t].exp);
    end

    // Random coefficients and random samples, checked against the model.
    for (int i = 0; i < TAPS; i++) load_coef(int'($urandom_range(0, 255)) - 128);
    for (int j = 0; j < 20; j++) begin
      r = int'($urandom_range(0, 255)) - 128;
      run_sample(r, 1'b0, y, lat);
      e = model_accept(r);
      check("rand_y", y, e);
      check("rand_lat", lat, 9);
    end

    // Handshake timing with in_valid held high continuously.
    hs_done = 1'b0; last = -1; nacc = 0; e = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    for (int c = 0; c < 60 && !hs_done; c++) begin
      if (c > 0) @(negedge clk);
      if (last >= 0) begin
        if (cyc == last) in_data = 8'($urandom);
        if (cyc >= last && cyc <= last + 8) begin
          check("hs_ready_low", int'(in_ready), 0);
          check("hs_busy_high", int'(busy), 1);
        end
        check("hs_out_valid", int'(out_valid), int'(cyc == last + 9));
        if (cyc == last + 9) begin
          check("hs_busy_done", int'(busy), 0);
          check("hs_y", int'(out_data), e);
          if (nacc == 3) begin
            in_valid = 1'b0;
            hs_done  = 1'b1;
          end
        end
      end
      if (!hs_done && in_valid && in_ready) begin
        if (last >= 0) check("hs_spacing", cyc + 1 - last, 10);
        last = cyc + 1;
        e = model_accept(int'(in_data));
        nacc++;
      end
    end
    in_valid = 1'b0;
    check("hs_completed", int'(hs_done), 1);

    // Coefficients stay frozen during MAC.
    for (int i = 0; i < TAPS; i++) load_coef((i < 7) ? (64 >> i) : 0);
    for (int j = 0; j < TAPS; j++) begin
      run_sample(0, 1'b0, y, lat);
      e = model_accept(0);
      check("flush_y", y, e);
    end
    for (int i = 0; i < TAPS; i++) begin
      run_sample(imp[i].sample, (i == 0), y, lat);
      void'(model_accept(imp[i].sample));
      check("frozen_y", y, imp[i].exp);
    end

    // coef_load and in_valid together in IDLE: the load wins and the sample is dropped.
    @(negedge clk);
    coef_load = 1'b1; coef_data = 8'sd5; in_valid = 1'b1; in_data = 8'sd99;
    #1;
    check("cl_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    check("cl_busy", int'(busy), 0);
    coef_load = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < TAPS - 1; k++) mc[k] = mc[k+1];
    mc[TAPS-1] = 5;
    #1;
    check("cl_ready_back", int'(in_ready), 1);
    for (int j = 0; j < TAPS; j++) begin
      r = int'($urandom_range(1, 255)) - 128;
      run_sample(r, 1'b0, y, lat);
      e = model_accept(r);
      check("cl_y", y, e);
    end

    // Reset asserted mid-computation, at E3.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'sd50;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_busy", int'(busy), 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_data", int'(out_data), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_no_pulse", int'(out_valid), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (15) begin
      @(negedge clk);
      check("post_rst_no_pulse", int'(out_valid), 0);
    end
    r = 77;
    run_sample(r, 1'b0, y, lat);
    e = model_accept(r);
    check("post_rst_y", y, e);
    check("post_rst_zero", y, 0);
    check("post_rst_lat", lat, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_mac_seq.md
# fir_mac_seq

Parametrised, time-multiplexed FIR filter core: one signed multiplier/accumulator computes each output over TAPS cycles. Coefficients load serially at runtime, samples enter on a valid/ready handshake, and results leave as a single-cycle valid pulse. It is the generalised successor of the fixed 8-bit FIR behind the TinyTapeout top level. Tap count, data width, coefficient width, output width and output scaling are configurable, and it adds backpressure, a busy indication and selectable overflow handling.

## Interface
- DATA_W, 8, sample width, signed two's complement
- COEF_W, 8, coefficient width, signed two's complement
- TAPS, 8, number of taps; must be ≥2
- OUT_W, 10, output width, signed
- SHIFT, 6, arithmetic right shift applied to the accumulator before output
- ACC_W (localparam) = DATA_W+COEF_W+$clog2(TAPS)

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample offered
- in_ready  out  1  core accepts a sample this cycle
- in_data  in  DATA_W  sample x[n]
- coef_load  in  1  shift coef_data into the coefficient chain this cycle
- coef_data  in  COEF_W  coefficient word
- out_valid  out  1  one-cycle pulse: out_data holds a new y[n]
- out_data  out  OUT_W  filtered sample
- busy  out  1  high in MAC and DONE states

## Operation
- Reset: state IDLE, delay line x[0..TAPS-1]=0, coef[0..TAPS-1]=0, acc=0, idx=0, out_data=0, out_valid=0, busy=0.
- in_ready = (state==IDLE) && !coef_load. This signal is combinational. After reset, in_ready=1 whenever coef_load=0.
- Coefficient load applies only in IDLE, at an edge with coef_load=1:
  - coef[TAPS-1]<=coef_data and coef[k]<=coef[k+1].
  - After TAPS load cycles with words c0..c(TAPS-1), coef[k]=ck.
  - coef_load outside IDLE is ignored; coefficients stay frozen during a computation.
  - coef_load has priority over in_valid in IDLE.
- Sample accept: at an edge with in_valid && in_ready:
  - x[0]<=in_data and x[k]<=x[k-1].
  - acc<=0, idx<=0, state→MAC.
- MAC: each edge performs acc<=acc+x[idx]*coef[idx] (full-precision signed product, ACC_W accumulator, no overflow possible) and increments idx. When idx==TAPS-1, state→DONE.
- DONE: one edge performs:
  - out_data<=scale(acc>>>SHIFT)
  - out_valid<=1
  - state→IDLE
- out_valid returns to 0 on the next edge. out_data holds until the next result.
- There is no output backpressure. Downstream logic must capture out_data on the out_valid pulse.
- Result: y[n] = Σ ck·x[n−k] >>> SHIFT. Delay line contents persist across samples.

## Timing
- Label the accept edge E0:
  - MAC products occur on edges E1..E_TAPS.
  - out_valid is high in the cycle following E_(TAPS+1).
  - Latency is TAPS+1 edges.
- in_ready is high again in the same cycle as out_valid. The next accept is earliest at E_(TAPS+2). Maximum throughput is one sample per TAPS+2 cycles.
- busy is high from the cycle after E0 through the cycle ending at E_(TAPS+1).
- in_valid while busy is not consumed. The source must hold in_valid until it is accepted.
- rst_n low at any time: immediate asynchronous return to the reset state. Any in-flight result is discarded, and no out_valid pulse is produced.

## Configuration
- FIR_SAT_EN defined: scale() saturates acc>>>SHIFT to the range [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- FIR_SAT_EN undefined: scale() keeps the low OUT_W bits (two's-complement wrap).

## Test plan
All scenarios use the default parameters.
- Impulse: load coefficients 64,32,16,8,4,2,1,0, then feed 64 followed by seven 0 samples → out_data sequence 64,32,16,8,4,2,1,0.
- Latency/handshake: in_valid held high continuously → out_valid exactly 9 edges after each accept; accepts spaced exactly 10 cycles apart; in_ready=0 and busy=1 for the 9 cycles after each accept.
- Overflow: coefficients all 127, eight samples of 127 → last output 511 with FIR_SAT_EN, −32 without it. Samples of −128 instead → −512 with FIR_SAT_EN, 16 without it.
- Frozen coefficients: pulse coef_load with coef_data=−1 during MAC → no coefficient change; impulse response identical to the impulse scenario. coef_load=1 and in_valid=1 together in IDLE → load occurs, sample not accepted, in_ready=0.
- Reset mid-operation: drop rst_n at E3 after an accept → out_valid never pulses; outputs and state return to 0/IDLE immediately; after release, a zero-coefficient filter outputs 0.
